// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer between decode and dispatch.
// Holds the per-lane payload fields and the buffer entry layout.
package inst_buffer_pkg;

  localparam int IB_WIDTH = 3;
  localparam int IB_DEPTH = 16;

  typedef logic [6:0]  opt_t;
  typedef logic [2:0]  fun_t;
  typedef logic [1:0]  sel_t;
  typedef logic [31:0] pc_t;
  typedef logic [31:0] imm_t;
  typedef logic [4:0]  reg_t;
  typedef logic [3:0]  exc_t;

  typedef struct packed {
    opt_t            opt;
    fun_t            fun;
    sel_t [1:0]      sel;
    pc_t             pc;
    imm_t            imm;
    reg_t [1:0]      src;
    reg_t            dst;
    exc_t            exc;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer_popcount.sv
// Counts set lanes running contiguously from lane 0.
// Lanes above the first clear lane are ignored.
module popcount_lanes #(
  parameter int WIDTH = 3,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] lanes,
  output logic [CW-1:0]    cnt
);

  logic run;

  always_comb begin
    run = 1'b1;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & lanes[i];
      if (run) cnt = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Multi-lane circular instruction buffer from decode to dispatch.
// Dispatch reads storage combinationally; writes land a cycle later.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int WIDTH = IB_WIDTH,
  parameter int DEPTH = IB_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic [WIDTH-1:0] avail,
  input  logic [WIDTH-1:0] valid,
  input  opt_t             opt [WIDTH],
  input  fun_t             fun [WIDTH],
  input  sel_t [1:0]       sel [WIDTH],
  input  pc_t              pc  [WIDTH],
  input  imm_t             imm [WIDTH],
  input  reg_t [1:0]       src [WIDTH],
  input  reg_t             dst [WIDTH],
  input  exc_t             exc [WIDTH],
  output logic [WIDTH-1:0] out_valid,
  input  logic [WIDTH-1:0] out_ready,
  output opt_t             out_opt [WIDTH],
  output fun_t             out_fun [WIDTH],
  output sel_t [1:0]       out_sel [WIDTH],
  output pc_t              out_pc  [WIDTH],
  output imm_t             out_imm [WIDTH],
  output reg_t [1:0]       out_src [WIDTH],
  output reg_t             out_dst [WIDTH],
  output exc_t             out_exc [WIDTH]
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic [AW:0]      free;
  logic [CW-1:0]    n_in;
  logic [CW-1:0]    n_out;
  logic [WIDTH-1:0] wr;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] vinc;
  logic [WIDTH-1:0] rinc;
  ib_entry_t        mem    [DEPTH];
  ib_entry_t        in_ent [WIDTH];

  assign free = (AW+1)'(DEPTH) - count;

  // Both vectors are forced low while reset is held.
  always_comb begin
    avail     = '0;
    out_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      avail[i]     = !reset && (free >= (AW+1)'(i + 1));
      out_valid[i] = !reset && (count > (AW+1)'(i));
    end
  end

  assign wr = valid & avail;
  assign rd = out_valid & out_ready;

  popcount_lanes #(.WIDTH(WIDTH), .CW(CW)) u_pc_in (
    .lanes (wr),
    .cnt   (n_in)
  );

  popcount_lanes #(.WIDTH(WIDTH), .CW(CW)) u_pc_out (
    .lanes (rd),
    .cnt   (n_out)
  );

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      in_ent[i].opt = opt[i];
      in_ent[i].fun = fun[i];
      in_ent[i].sel = sel[i];
      in_ent[i].pc  = pc[i];
      in_ent[i].imm = imm[i];
      in_ent[i].src = src[i];
      in_ent[i].dst = dst[i];
      in_ent[i].exc = exc[i];
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_opt[i] = mem[head + AW'(i)].opt;
      out_fun[i] = mem[head + AW'(i)].fun;
      out_sel[i] = mem[head + AW'(i)].sel;
      out_pc[i]  = mem[head + AW'(i)].pc;
      out_imm[i] = mem[head + AW'(i)].imm;
      out_src[i] = mem[head + AW'(i)].src;
      out_dst[i] = mem[head + AW'(i)].dst;
      out_exc[i] = mem[head + AW'(i)].exc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_out);
      tail  <= tail + AW'(n_in);
      count <= count + (AW+1)'(n_in) - (AW+1)'(n_out);
    end
  end

  // Payload storage is never cleared; only the pointers are.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr[i]) mem[tail + AW'(i)] <= in_ent[i];
      end
    end
  end

  assign vinc = valid + WIDTH'(1);
  assign rinc = out_ready + WIDTH'(1);

  a_valid_contig : assert property (
    @(posedge clock) disable iff (reset) ((valid & vinc) == '0));

  a_ready_contig : assert property (
    @(posedge clock) disable iff (reset) ((out_ready & rinc) == '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with a pc scoreboard on dispatch.
// Expected flags per step are hand-derived for WIDTH=3, DEPTH=8.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int W = 3;
  localparam int D = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] avail;
  logic [W-1:0] valid = '0;
  opt_t         opt [W];
  fun_t         fun [W];
  sel_t [1:0]   sel [W];
  pc_t          pc  [W];
  imm_t         imm [W];
  reg_t [1:0]   src [W];
  reg_t         dst [W];
  exc_t         exc [W];
  logic [W-1:0] out_valid;
  logic [W-1:0] out_ready = '0;
  opt_t         out_opt [W];
  fun_t         out_fun [W];
  sel_t [1:0]   out_sel [W];
  pc_t          out_pc  [W];
  imm_t         out_imm [W];
  reg_t [1:0]   out_src [W];
  reg_t         out_dst [W];
  exc_t         out_exc [W];

  int checks   = 0;
  int failures = 0;
  int mcount   = 0;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] sbq [$];

  always #5 clock = ~clock;

  inst_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .avail     (avail),
    .valid     (valid),
    .opt       (opt),
    .fun       (fun),
    .sel       (sel),
    .pc        (pc),
    .imm       (imm),
    .src       (src),
    .dst       (dst),
    .exc       (exc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opt   (out_opt),
    .out_fun   (out_fun),
    .out_sel   (out_sel),
    .out_pc    (out_pc),
    .out_imm   (out_imm),
    .out_src   (out_src),
    .out_dst   (out_dst),
    .out_exc   (out_exc)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pay(input logic [31:0] p);
    logic [1:0] s1;
    s1 = ~p[3:2];
    return {~p, p[6:2] ^ 5'h1f, p[5:2], s1, p[3:2],
            p[7:3], p[6:2], p[8:2], p[4:2]};
  endfunction

  function automatic logic [W-1:0] lanes(input int n);
    int m;
    m = (1 << n) - 1;
    return W'(m);
  endfunction

  // Monitor: every handshaken dispatch lane pops the scoreboard.
  always @(negedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < W; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sbq.size() == 0) begin
            chk("spurious_dispatch", 128'(out_pc[i]), 128'hdead);
          end else begin
            logic [31:0] e;
            e = sbq.pop_front();
            chk("out_pc", 128'(out_pc[i]), 128'(e));
            chk("out_payload",
                {out_imm[i], out_dst[i], out_exc[i], out_sel[i],
                 out_src[i], out_opt[i], out_fun[i]}, pay(e));
          end
        end
      end
    end
  end

  task automatic step(input int nv, input int nr, input bit fl,
                      input bit rs, input logic [W-1:0] ea,
                      input logic [W-1:0] eo, input string nm);
    int ni, no, fr;
    reset     = rs;
    flush     = fl;
    valid     = lanes(nv);
    out_ready = lanes(nr);
    for (int i = 0; i < W; i++) begin
      logic [31:0] p;
      p      = next_pc + 32'(4 * i);
      pc[i]  = p;
      imm[i] = ~p;
      dst[i] = p[6:2] ^ 5'h1f;
      exc[i] = p[5:2];
      sel[i] = {~p[3:2], p[3:2]};
      src[i] = {p[7:3], p[6:2]};
      opt[i] = p[8:2];
      fun[i] = p[4:2];
    end
    fr = D - mcount;
    ni = rs ? 0 : ((nv < fr) ? nv : fr);
    no = rs ? 0 : ((nr < mcount) ? nr : mcount);
    if (!rs && !fl) begin
      for (int i = 0; i < ni; i++) sbq.push_back(next_pc + 32'(4 * i));
    end
    next_pc = next_pc + 32'(4 * nv);
    @(negedge clock);
    chk({nm, ".avail"}, 128'(avail), 128'(ea));
    chk({nm, ".out_valid"}, 128'(out_valid), 128'(eo));
    @(posedge clock);
    #1;
    if (rs || fl) begin
      mcount = 0;
      sbq.delete();
    end else begin
      mcount = mcount + ni - no;
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    step(0, 0, 0, 1, 3'b000, 3'b000, "reset");
    step(3, 0, 0, 0, 3'b111, 3'b000, "first_enq");
    step(0, 3, 0, 0, 3'b111, 3'b111, "first_deq");
    step(3, 0, 0, 0, 3'b111, 3'b000, "fill1");
    step(3, 0, 0, 0, 3'b111, 3'b111, "fill2");
    step(3, 0, 0, 0, 3'b011, 3'b111, "fill3");
    step(0, 0, 0, 0, 3'b000, 3'b111, "full");
    step(3, 3, 0, 0, 3'b000, 3'b111, "full_rw");
    step(0, 0, 0, 0, 3'b111, 3'b111, "after_rw");
    step(3, 0, 1, 0, 3'b111, 3'b111, "flush");
    step(0, 0, 0, 0, 3'b111, 3'b000, "post_flush");
    step(3, 0, 0, 0, 3'b111, 3'b000, "wrap_f1");
    step(3, 0, 0, 0, 3'b111, 3'b111, "wrap_f2");
    step(1, 0, 0, 0, 3'b011, 3'b111, "wrap_f3");
    step(0, 3, 0, 0, 3'b001, 3'b111, "wrap_d1");
    step(0, 3, 0, 0, 3'b111, 3'b111, "wrap_d2");
    step(3, 0, 0, 0, 3'b111, 3'b001, "wrap_enq");
    step(0, 3, 0, 0, 3'b111, 3'b111, "wrap_d3");
    step(0, 3, 0, 0, 3'b111, 3'b001, "wrap_d4");
    step(0, 0, 0, 0, 3'b111, 3'b000, "wrap_empty");
    step(3, 0, 0, 0, 3'b111, 3'b000, "r_f1");
    step(1, 0, 0, 0, 3'b111, 3'b111, "r_f2");
    step(3, 0, 1, 1, 3'b000, 3'b000, "reset_flush");
    step(0, 0, 0, 0, 3'b111, 3'b000, "post_reset");
    step(0, 3, 0, 0, 3'b111, 3'b000, "idle_ready");
    step(0, 0, 0, 0, 3'b111, 3'b000, "still_empty");
    step(2, 1, 0, 0, 3'b111, 3'b000, "enq2");
    step(1, 1, 0, 0, 3'b111, 3'b011, "mix_rw");
    step(0, 3, 0, 0, 3'b111, 3'b011, "drain");
    step(0, 0, 0, 0, 3'b111, 3'b000, "final");
    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
